// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: requester and memory-side signals of the two-to-one bus
// arbiter, grouped into one bundle.
//   slave  : arbiter view (serves IFU/LSU requests, drives the memory port)
//   master : environment view (requesters and downstream memory)
interface bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // IFU requester
  logic                ifu_reqValid;
  logic [ADDR_W-1:0]   ifu_addr;
  logic                ifu_respValid;
  logic [DATA_W-1:0]   ifu_rdata;

  // LSU requester
  logic                lsu_reqValid;
  logic [ADDR_W-1:0]   lsu_addr;
  logic [1:0]          lsu_size;
  logic                lsu_wen;
  logic [DATA_W-1:0]   lsu_wdata;
  logic [DATA_W/8-1:0] lsu_wmask;
  logic                lsu_respValid;
  logic [DATA_W-1:0]   lsu_rdata;

  // Downstream memory port
  logic                mem_reqValid;
  logic [ADDR_W-1:0]   mem_addr;
  logic [1:0]          mem_size;
  logic                mem_wen;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wmask;
  logic                mem_respValid;
  logic [DATA_W-1:0]   mem_rdata;

  modport slave (
    input  ifu_reqValid, ifu_addr,
    output ifu_respValid, ifu_rdata,
    input  lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_respValid, lsu_rdata,
    output mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask,
    input  mem_respValid, mem_rdata
  );

  modport master (
    output ifu_reqValid, ifu_addr,
    input  ifu_respValid, ifu_rdata,
    output lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_respValid, lsu_rdata,
    input  mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask,
    output mem_respValid, mem_rdata
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the core's single memory port between the instruction
// fetch unit (IFU) and the load/store unit (LSU). One transaction is in
// flight at a time; the granted request is registered onto the memory port
// and the response is returned to the owner as a one-cycle registered pulse.
//
// Optional feature macro: BUS_ARB_RR_EN
//   defined   -> round-robin on simultaneous requests (pointer register)
//   undefined -> fixed priority, LSU wins simultaneous requests
module bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clock,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;

  logic                grant;
  logic                grant_ifu;
  logic                complete;
  logic                pick_ifu;

  logic                owner_ifu_q;
  logic                mem_req_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [1:0]          mem_size_q;
  logic                mem_wen_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [MASK_W-1:0]   mem_wmask_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                ifu_resp_q;
  logic                lsu_resp_q;

`ifdef BUS_ARB_RR_EN
  // 1: IFU preferred on the next simultaneous request; reset prefers LSU
  logic                rr_ifu_pref_q;
`endif

  // Winner selection, only meaningful when at least one request is up
  always_comb begin
    pick_ifu = 1'b0;
`ifdef BUS_ARB_RR_EN
    pick_ifu = bus.ifu_reqValid && (!bus.lsu_reqValid || rr_ifu_pref_q);
`else
    pick_ifu = bus.ifu_reqValid && !bus.lsu_reqValid;
`endif
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and grant/complete decode
  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    grant_ifu = 1'b0;
    complete  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.ifu_reqValid || bus.lsu_reqValid) begin
          grant     = 1'b1;
          grant_ifu = pick_ifu;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (bus.mem_respValid) begin
          complete = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory-port request registers, shared rdata and response pulses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_ifu_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_size_q  <= '0;
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      rdata_q     <= '0;
      ifu_resp_q  <= 1'b0;
      lsu_resp_q  <= 1'b0;
    end else begin
      ifu_resp_q <= 1'b0;
      lsu_resp_q <= 1'b0;
      if (grant) begin
        mem_req_q   <= 1'b1;
        owner_ifu_q <= grant_ifu;
        if (grant_ifu) begin
          mem_addr_q  <= bus.ifu_addr;
          mem_size_q  <= 2'd2;
          mem_wen_q   <= 1'b0;
          mem_wdata_q <= '0;
          mem_wmask_q <= '1;
        end else begin
          mem_addr_q  <= bus.lsu_addr;
          mem_size_q  <= bus.lsu_size;
          mem_wen_q   <= bus.lsu_wen;
          mem_wdata_q <= bus.lsu_wdata;
          mem_wmask_q <= bus.lsu_wmask;
        end
      end
      if (complete) begin
        mem_req_q  <= 1'b0;
        rdata_q    <= bus.mem_rdata;
        ifu_resp_q <= owner_ifu_q;
        lsu_resp_q <= !owner_ifu_q;
      end
    end
  end

`ifdef BUS_ARB_RR_EN
  // Round-robin pointer: after each grant, prefer the other requester
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ifu_pref_q <= 1'b0;
    end else if (grant) begin
      rr_ifu_pref_q <= !grant_ifu;
    end
  end
`endif

  assign bus.mem_reqValid  = mem_req_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_size      = mem_size_q;
  assign bus.mem_wen       = mem_wen_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_wmask     = mem_wmask_q;

  assign bus.ifu_respValid = ifu_resp_q;
  assign bus.lsu_respValid = lsu_resp_q;
  assign bus.ifu_rdata     = rdata_q;
  assign bus.lsu_rdata     = rdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed self-checking bench for bus_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_bus_arbiter;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.ifu_reqValid  = 1'b0;
    bus.ifu_addr      = '0;
    bus.lsu_reqValid  = 1'b0;
    bus.lsu_addr      = '0;
    bus.lsu_size      = '0;
    bus.lsu_wen       = 1'b0;
    bus.lsu_wdata     = '0;
    bus.lsu_wmask     = '0;
    bus.mem_respValid = 1'b0;
    bus.mem_rdata     = '0;
  endtask

  initial begin
    logic [7:0]  exp_lsu;
    logic [31:0] held_addr;
    int          ifu_left;
    int          lsu_left;
    int          waited;
    logic        got_lsu;

    checks = 0;
    errors = 0;
    reset  = 1'b0;
    idle_inputs();
    tick();
    tick();

    // Reset values
    check("rst_mem_reqValid", bus.mem_reqValid, 1'b0);
    check("rst_resp", {bus.ifu_respValid, bus.lsu_respValid}, 2'b00);
    check("rst_mem_fields", {bus.mem_addr, bus.mem_size, bus.mem_wen, bus.mem_wmask}, '0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_rdata", {bus.ifu_rdata, bus.lsu_rdata}, 64'h0);
    reset = 1'b1;
    tick();

    // IFU read, k=2
    bus.ifu_reqValid = 1'b1;
    bus.ifu_addr     = 32'h8000_0000;
    tick();
    check("ifu_req_c1", bus.mem_reqValid, 1'b1);
    check("ifu_fields", {bus.mem_addr, bus.mem_size, bus.mem_wen, bus.mem_wmask},
          {32'h8000_0000, 2'd2, 1'b0, 4'hF});
    tick();
    check("ifu_req_c2", bus.mem_reqValid, 1'b1);
    tick();
    check("ifu_req_c3", bus.mem_reqValid, 1'b1);
    check("ifu_no_early_resp", {bus.ifu_respValid, bus.lsu_respValid}, 2'b00);
    bus.mem_respValid = 1'b1;
    bus.mem_rdata     = 32'h0000_0013;
    tick();
    bus.mem_respValid = 1'b0;
    bus.mem_rdata     = 32'h0;
    bus.ifu_reqValid  = 1'b0;
    check("ifu_req_drop", bus.mem_reqValid, 1'b0);
    check("ifu_resp_pulse", {bus.ifu_respValid, bus.lsu_respValid}, 2'b10);
    check("ifu_rdata", bus.ifu_rdata, 32'h0000_0013);
    tick();
    check("ifu_resp_one_cycle", {bus.ifu_respValid, bus.lsu_respValid}, 2'b00);
    check("ifu_no_regrant", bus.mem_reqValid, 1'b0);
    tick();

    // LSU write, k=0 (completion in the first BUSY cycle)
    bus.lsu_reqValid = 1'b1;
    bus.lsu_addr     = 32'h8000_0100;
    bus.lsu_wdata    = 32'hDEAD_BEEF;
    bus.lsu_wmask    = 4'h3;
    bus.lsu_size     = 2'd1;
    bus.lsu_wen      = 1'b1;
    tick();
    check("lsu_req", bus.mem_reqValid, 1'b1);
    check("lsu_fields", {bus.mem_addr, bus.mem_size, bus.mem_wen, bus.mem_wmask},
          {32'h8000_0100, 2'd1, 1'b1, 4'h3});
    check("lsu_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    bus.mem_respValid = 1'b1;
    bus.mem_rdata     = 32'hAAAA_5555;
    tick();
    bus.mem_respValid = 1'b0;
    bus.lsu_reqValid  = 1'b0;
    check("lsu_resp_pulse", {bus.ifu_respValid, bus.lsu_respValid}, 2'b01);
    check("lsu_rdata", bus.lsu_rdata, 32'hAAAA_5555);
    check("lsu_req_drop", bus.mem_reqValid, 1'b0);
    tick();
    // IDLE now: a request here is granted at the next edge
    check("lsu_resp_one_cycle", {bus.ifu_respValid, bus.lsu_respValid}, 2'b00);
    bus.ifu_reqValid = 1'b1;
    bus.ifu_addr     = 32'h8000_0004;
    tick();
    check("idle_after_lsu", bus.mem_reqValid, 1'b1);
    check("idle_after_lsu_addr", bus.mem_addr, 32'h8000_0004);

    // Reset pulse so the arbitration run starts from the reset pointer
    reset = 1'b0;
    idle_inputs();
    tick();
    reset = 1'b1;
    tick();

    // Simultaneous requests, 4 transactions each
`ifdef BUS_ARB_RR_EN
    exp_lsu = 8'b0101_0101;
`else
    exp_lsu = 8'b0000_1111;
`endif
    ifu_left         = 4;
    lsu_left         = 4;
    bus.ifu_addr     = 32'h1000_0000;
    bus.lsu_addr     = 32'h2000_0000;
    bus.lsu_size     = 2'd2;
    bus.lsu_wen      = 1'b0;
    bus.lsu_wmask    = 4'hF;
    bus.ifu_reqValid = 1'b1;
    bus.lsu_reqValid = 1'b1;
    for (int n = 0; n < 8; n++) begin
      waited = 0;
      while (!bus.mem_reqValid && waited < 8) begin
        tick();
        waited++;
      end
      check("arb_grant_seen", bus.mem_reqValid, 1'b1);
      got_lsu = (bus.mem_addr[31:28] == 4'h2);
      check("arb_order", got_lsu, exp_lsu[n]);
      bus.mem_respValid = 1'b1;
      bus.mem_rdata     = 32'h100 + n;
      tick();
      bus.mem_respValid = 1'b0;
      check("arb_resp", {bus.ifu_respValid, bus.lsu_respValid},
            exp_lsu[n] ? 2'b01 : 2'b10);
      check("arb_rdata", bus.ifu_rdata, 32'h100 + n);
      if (got_lsu) begin
        lsu_left--;
        bus.lsu_addr = bus.lsu_addr + 32'd4;
        if (lsu_left == 0) bus.lsu_reqValid = 1'b0;
      end else begin
        ifu_left--;
        bus.ifu_addr = bus.ifu_addr + 32'd4;
        if (ifu_left == 0) bus.ifu_reqValid = 1'b0;
      end
    end
    tick();
    tick();
    check("arb_all_done", {bus.mem_reqValid, bus.ifu_reqValid, bus.lsu_reqValid}, 3'b000);

    // Long stall in BUSY with a toggling IFU address
    bus.ifu_reqValid = 1'b1;
    bus.ifu_addr     = 32'h8000_0200;
    held_addr        = 32'h8000_0200;
    tick();
    for (int c = 0; c < 20; c++) begin
      bus.ifu_addr = bus.ifu_addr ^ 32'h0000_FFF0;
      tick();
      check("stall_hold", {bus.mem_reqValid, bus.mem_addr, bus.mem_size, bus.mem_wen, bus.mem_wmask},
            {1'b1, held_addr, 2'd2, 1'b0, 4'hF});
    end
    bus.ifu_addr      = held_addr;
    bus.mem_respValid = 1'b1;
    bus.mem_rdata     = 32'h1234_5678;
    tick();
    bus.mem_respValid = 1'b0;
    bus.ifu_reqValid  = 1'b0;
    check("stall_resp", {bus.ifu_respValid, bus.lsu_respValid, bus.ifu_rdata}, {2'b10, 32'h1234_5678});
    tick();

    // Reset asserted mid-BUSY
    bus.lsu_reqValid = 1'b1;
    bus.lsu_addr     = 32'h8000_0300;
    bus.lsu_wen      = 1'b1;
    bus.lsu_wdata    = 32'hCAFE_F00D;
    bus.lsu_wmask    = 4'hF;
    bus.lsu_size     = 2'd2;
    tick();
    check("midrst_busy", bus.mem_reqValid, 1'b1);
    reset = 1'b0;
    #1;
    check("midrst_req_zero", bus.mem_reqValid, 1'b0);
    check("midrst_fields_zero", {bus.mem_addr, bus.mem_size, bus.mem_wen, bus.mem_wmask}, '0);
    check("midrst_wdata_zero", bus.mem_wdata, 32'h0);
    check("midrst_rdata_zero", bus.lsu_rdata, 32'h0);
    check("midrst_resp_zero", {bus.ifu_respValid, bus.lsu_respValid}, 2'b00);
    idle_inputs();
    tick();
    reset = 1'b1;
    tick();
    bus.mem_respValid = 1'b1;
    bus.mem_rdata     = 32'hBAD0_BAD0;
    tick();
    bus.mem_respValid = 1'b0;
    check("late_resp_ignored", {bus.mem_reqValid, bus.ifu_respValid, bus.lsu_respValid}, 3'b000);
    tick();
    check("late_resp_no_pulse", {bus.ifu_respValid, bus.lsu_respValid}, 2'b00);
    check("late_resp_rdata", bus.ifu_rdata, 32'h0);

    // Normal grant after reset release
    bus.ifu_reqValid = 1'b1;
    bus.ifu_addr     = 32'h8000_0040;
    tick();
    check("post_rst_grant", {bus.mem_reqValid, bus.mem_addr}, {1'b1, 32'h8000_0040});
    bus.mem_respValid = 1'b1;
    bus.mem_rdata     = 32'h0000_0093;
    tick();
    bus.mem_respValid = 1'b0;
    bus.ifu_reqValid  = 1'b0;
    check("post_rst_resp", {bus.ifu_respValid, bus.lsu_respValid, bus.ifu_rdata}, {2'b10, 32'h0000_0093});
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
